// File: rtl/alu_pkg.sv
// Shared ALU definitions: function select codes and the divider state encoding.
package alu_pkg;

    localparam logic [1:0] FUNC_ADD = 2'b00;
    localparam logic [1:0] FUNC_SUB = 2'b01;
    localparam logic [1:0] FUNC_MUL = 2'b10;
    localparam logic [1:0] FUNC_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between the ALU (master) and the sequential divider (slave).
interface div_seq_if #(parameter int width = 6);

    logic               start;
    logic [width-1:0]   a;
    logic [width-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*width-1:0] out;
    logic               ovf;

    modport master (output start, a, b, input busy, done, out, ovf);
    modport slave  (input start, a, b, output busy, done, out, ovf);

endinterface

// File: rtl/div_step.sv
// One restoring-division stage: shift in the next dividend bit, trial-subtract, select.
module div_step #(
    parameter int width = 6
) (
    input  logic [width-1:0] rem_in,
    input  logic             msb_in,
    input  logic [width-1:0] divisor,
    output logic [width-1:0] rem_out,
    output logic             q_bit
);

    logic [width:0] shifted;
    logic [width:0] diff;

    always_comb begin
        shifted = {rem_in, msb_in};
        diff    = shifted - {1'b0, divisor};
        // A clear borrow bit means the trial subtraction did not go negative
        q_bit   = ~diff[width];
        rem_out = q_bit ? diff[width-1:0] : shifted[width-1:0];
    end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per clock; results as {remainder, quotient}.
// Define DIV_SIGNED_EN for two's-complement truncating division around the same unsigned core.
module div_seq
    import alu_pkg::*;
#(
    parameter int width = 6
) (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);

    localparam int CNT_W = (width > 1) ? $clog2(width) : 1;

    div_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [width-1:0] rem_reg, quo_reg, div_reg;
    logic             ovf_pend_reg;
    logic [2*width-1:0] out_reg;
    logic             ovf_reg, done_reg;

    logic             accept, div_zero, last_iter;
    logic [width-1:0] step_rem;
    logic             step_q;
    logic [width-1:0] a_core, b_core, res_q, res_r;
    logic             ovf_cap;

`ifdef DIV_SIGNED_EN
    logic neg_q_reg, neg_r_reg;

    always_comb begin
        a_core  = bus.a[width-1] ? width'(0) - bus.a : bus.a;
        b_core  = bus.b[width-1] ? width'(0) - bus.b : bus.b;
        ovf_cap = (bus.a == {1'b1, {(width-1){1'b0}}}) && (bus.b == {width{1'b1}});
        res_q   = neg_q_reg ? width'(0) - quo_reg : quo_reg;
        res_r   = neg_r_reg ? width'(0) - rem_reg : rem_reg;
    end
`else
    always_comb begin
        a_core  = bus.a;
        b_core  = bus.b;
        ovf_cap = 1'b0;
        res_q   = quo_reg;
        res_r   = rem_reg;
    end
`endif

    assign accept    = bus.start && (state_reg != CALC);
    assign div_zero  = (bus.b == '0);
    assign last_iter = (cnt_reg == CNT_W'(width - 1));

    div_step #(.width(width)) u_step (
        .rem_in  (rem_reg),
        .msb_in  (quo_reg[width-1]),
        .divisor (div_reg),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (state_reg == DONE) state_next = IDLE;
                if (bus.start)         state_next = div_zero ? DONE : CALC;
            end
            CALC:    if (last_iter) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            div_reg      <= '0;
            ovf_pend_reg <= 1'b0;
            out_reg      <= '0;
            ovf_reg      <= 1'b0;
            done_reg     <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
`endif
        end else begin
            done_reg <= (state_reg == DONE);
            // Result is taken from the pre-edge registers, so a back-to-back capture is safe
            if (state_reg == DONE) begin
                out_reg <= {res_r, res_q};
                ovf_reg <= ovf_pend_reg;
            end
            if (accept) begin
                cnt_reg <= '0;
                div_reg <= b_core;
                if (div_zero) begin
                    rem_reg      <= bus.a;
                    quo_reg      <= '1;
                    ovf_pend_reg <= 1'b1;
`ifdef DIV_SIGNED_EN
                    neg_q_reg    <= 1'b0;
                    neg_r_reg    <= 1'b0;
`endif
                end else begin
                    rem_reg      <= '0;
                    quo_reg      <= a_core;
                    ovf_pend_reg <= ovf_cap;
`ifdef DIV_SIGNED_EN
                    neg_q_reg    <= bus.a[width-1] ^ bus.b[width-1];
                    neg_r_reg    <= bus.a[width-1];
`endif
                end
            end else if (state_reg == CALC) begin
                rem_reg <= step_rem;
                quo_reg <= {quo_reg[width-2:0], step_q};
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign bus.busy = (state_reg == CALC);
    assign bus.done = done_reg;
    assign bus.out  = out_reg;
    assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq (width 6): latency, results, back-to-back, ignored start, reset abort.
module tb_div_seq;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   n;
    int   m;
    logic seen;

    always #5 clk = ~clk;

    div_seq_if #(.width(6)) bus ();

    div_seq #(.width(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (bus.done !== 1'b1 && cnt < 20);
    endtask

    task automatic run_op(input string tag, input logic [5:0] a, input logic [5:0] b,
                          input int exp_out, input logic exp_ovf, input int exp_lat);
        int lat;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_out"}, bus.out, exp_out);
        chk({tag, "_ovf"}, bus.ovf, exp_ovf);
        tick();
        chk({tag, "_done_pulse"}, bus.done, 1'b0);
        $display("op %s a=%0d b=%0d out=%0d ovf=%0d latency=%0d", tag, a, b, bus.out, bus.ovf, lat);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_out",  bus.out,  0);
        chk("rst_ovf",  bus.ovf,  1'b0);

`ifdef DIV_SIGNED_EN
        run_op("d45_7", 6'd45, 6'd7, 59*64 + 62, 1'b0, 7);   // -19/7: r=-5 q=-2
`else
        run_op("d45_7", 6'd45, 6'd7, 3*64 + 6, 1'b0, 7);
`endif
        run_op("d5_0", 6'd5, 6'd0, 5*64 + 63, 1'b1, 1);

        // Back-to-back: start held high, second operands presented while busy
        bus.a     = 6'd63;
        bus.b     = 6'd1;
        bus.start = 1'b1;
        tick();
        chk("b2b_busy", bus.busy, 1'b1);
        bus.a = 6'd1;
        bus.b = 6'd63;
        wait_done(n);
        bus.start = 1'b0;
        chk("b2b1_lat", n, 7);
        chk("b2b1_out", bus.out, 63);
        wait_done(m);
        chk("b2b2_lat", m, 7);
`ifdef DIV_SIGNED_EN
        chk("b2b2_out", bus.out, 63);                         // 1/-1 = -1 r0
`else
        chk("b2b2_out", bus.out, 64);
`endif
        chk("b2b2_ovf", bus.ovf, 1'b0);
        $display("op b2b first_lat=%0d second_lat=%0d out=%0d", n, m, bus.out);

        // Start while busy must be ignored
        bus.a     = 6'd20;
        bus.b     = 6'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        bus.a     = 6'd9;
        bus.b     = 6'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ign_busy", bus.busy, 1'b1);
        wait_done(n);
        chk("ign_lat", n, 4);
        chk("ign_out", bus.out, 2*64 + 6);
        chk("ign_ovf", bus.ovf, 1'b0);
        $display("op ignored_start out=%0d latency_after_pulse=%0d", bus.out, n);
        tick();

        // Reset mid-CALC, with a simultaneous start that reset must override
        bus.a     = 6'd10;
        bus.b     = 6'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        rst       = 1'b1;
        bus.a     = 6'd9;
        bus.b     = 6'd9;
        bus.start = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_out",  bus.out,  0);
        chk("abort_ovf",  bus.ovf,  1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", seen, 1'b0);
        $display("op reset_abort done_seen=%0d", seen);

`ifdef DIV_SIGNED_EN
        run_op("d50_6", 6'd50, 6'd6, 62*64 + 62, 1'b0, 7);   // -14/6: r=-2 q=-2
        run_op("sm20_3", 6'd44, 6'd3, 62*64 + 58, 1'b0, 7);
        run_op("sm32_m1", 6'd32, 6'd63, 32, 1'b1, 7);
`else
        run_op("d50_6", 6'd50, 6'd6, 2*64 + 8, 1'b0, 7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
